// File: rtl/apb_service_pkg.sv
// Shared register offsets and FSM state type for the APB event service controller.
package apb_service_pkg;

  // Word index within the slave window, decoded from PADDR[4:2]
  localparam logic [2:0] REG_ENABLE  = 3'd0;
  localparam logic [2:0] REG_PENDING = 3'd1;
  localparam logic [2:0] REG_SET     = 3'd2;
  localparam logic [2:0] REG_CLEAR   = 3'd3;
  localparam logic [2:0] REG_MODE    = 3'd4;
  localparam logic [2:0] REG_STATUS  = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } svc_state_e;

endpackage

// File: rtl/svc_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of req and whether any bit is set.
module svc_prio_enc #(
  parameter int NUM_CH = 32,
  parameter int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  output logic              valid,
  output logic [ID_W-1:0]   id
);

  // Scan from the top so the lowest set index is the last one written
  always_comb begin
    valid = |req;
    id    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/apb_service_ctrl.sv
// APB-programmable event service controller: per-channel level/edge pending bits,
// fixed-priority arbitration and a req/ack handshake towards the core.
//
// state | meaning
// IDLE  | no request outstanding; arbitrates over PENDING each cycle
// REQ   | irq_req_o high, irq_id_o frozen until ack or pending bit withdrawn
module apb_service_ctrl
  import apb_service_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_CH         = 32,
  parameter int ID_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_CH-1:0]         signal_i,
  output logic                      irq_req_o,
  output logic [ID_W-1:0]           irq_id_o,
  input  logic                      irq_ack_i
);

  svc_state_e        state_q;
  logic [NUM_CH-1:0] enable_q;
  logic [NUM_CH-1:0] mode_q;
  logic [NUM_CH-1:0] pending_q;
  logic [NUM_CH-1:0] pending_nxt;
  logic [NUM_CH-1:0] sig_q;
  logic [NUM_CH-1:0] hw_evt;
  logic [NUM_CH-1:0] set_wr;
  logic [NUM_CH-1:0] clr_wr;
  logic [NUM_CH-1:0] ack_clr;
  logic [NUM_CH-1:0] wdata_ch;
  logic [ID_W-1:0]   irq_id_q;
  logic [ID_W-1:0]   enc_id;
  logic              enc_valid;
  logic              access;
  logic              wr_en;
  logic              rd_en;
  logic              ack_ok;
  logic [2:0]        reg_sel;
  logic [31:0]       status;
  logic              unused_bits;

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;

  assign access   = PSEL & PENABLE;
  assign wr_en    = access & PWRITE;
  assign rd_en    = access & ~PWRITE;
  assign reg_sel  = PADDR[4:2];
  assign wdata_ch = PWDATA[NUM_CH-1:0];

  assign unused_bits = ^{PADDR, PWDATA};

  assign set_wr  = (wr_en && reg_sel == REG_SET)   ? wdata_ch : '0;
  assign clr_wr  = (wr_en && reg_sel == REG_CLEAR) ? wdata_ch : '0;
  assign ack_ok  = (state_q == REQ) & irq_ack_i;
  assign ack_clr = ack_ok ? (NUM_CH'(1) << irq_id_o) : '0;

  assign hw_evt = enable_q & ((mode_q & signal_i & ~sig_q) | (~mode_q & signal_i));

  // Hardware events are OR'd in last so a clear never swallows a same-cycle event
  always_comb begin
    pending_nxt = ((pending_q | hw_evt | set_wr) & ~clr_wr & ~ack_clr) | hw_evt;
    if (wr_en && reg_sel == REG_PENDING) pending_nxt = wdata_ch | hw_evt;
  end

  svc_prio_enc #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_prio_enc (
    .req   (pending_q),
    .valid (enc_valid),
    .id    (enc_id)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      enable_q  <= '0;
      mode_q    <= '0;
      pending_q <= '0;
      sig_q     <= '0;
    end else begin
      sig_q     <= signal_i;
      pending_q <= pending_nxt;
      if (wr_en && reg_sel == REG_ENABLE) enable_q <= wdata_ch;
      if (wr_en && reg_sel == REG_MODE)   mode_q   <= wdata_ch;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= IDLE;
      irq_id_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enc_valid) begin
            state_q  <= REQ;
            irq_id_q <= enc_id;
          end
        end
        REQ: begin
          // No preemption: only ack or software withdrawal releases the request
          if (ack_ok || !pending_q[irq_id_q]) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign irq_req_o = (state_q == REQ);
  assign irq_id_o  = irq_id_q;

  always_comb begin
    status           = '0;
    status[31]       = irq_req_o;
    status[ID_W-1:0] = irq_id_o;
  end

  always_comb begin
    PRDATA = '0;
    if (rd_en) begin
      case (reg_sel)
        REG_ENABLE:  PRDATA = 32'(enable_q);
        REG_PENDING: PRDATA = 32'(pending_q);
        REG_MODE:    PRDATA = 32'(mode_q);
        REG_STATUS:  PRDATA = status;
        default:     PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_service_ctrl.sv
// Scenario bench for apb_service_ctrl: expected ids/read data are queued at stimulus time.
module tb_apb_service_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [11:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] signal_i = '0;
  logic        irq_req_o;
  logic [4:0]  irq_id_o;
  logic        irq_ack_i = 1'b0;

  logic        psel8 = 1'b0;
  logic [31:0] prdata8;
  logic        pready8;
  logic        pslverr8;
  logic [7:0]  sig8 = '0;
  logic        req8;
  logic [2:0]  id8;
  logic        ack8 = 1'b0;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;
  logic [31:0] rdata;
  bit          got;
  int          nreq;

  always #5 HCLK = ~HCLK;

  apb_service_ctrl #(.APB_ADDR_WIDTH(12), .NUM_CH(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .signal_i(signal_i), .irq_req_o(irq_req_o), .irq_id_o(irq_id_o), .irq_ack_i(irq_ack_i)
  );

  apb_service_ctrl #(.APB_ADDR_WIDTH(12), .NUM_CH(8)) dut8 (
    .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(psel8), .PENABLE(PENABLE), .PRDATA(prdata8), .PREADY(pready8), .PSLVERR(pslverr8),
    .signal_i(sig8), .irq_req_o(req8), .irq_id_o(id8), .irq_ack_i(ack8)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apb_write(input bit to8, input logic [11:0] addr, input logic [31:0] data);
    @(negedge HCLK);
    PADDR = addr; PWDATA = data; PWRITE = 1'b1; PENABLE = 1'b0;
    if (to8) psel8 = 1'b1; else PSEL = 1'b1;
    @(negedge HCLK);
    PENABLE = 1'b1;
    @(negedge HCLK);
    PSEL = 1'b0; psel8 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input bit to8, input logic [11:0] addr, output logic [31:0] data);
    @(negedge HCLK);
    PADDR = addr; PWRITE = 1'b0; PENABLE = 1'b0;
    if (to8) psel8 = 1'b1; else PSEL = 1'b1;
    @(negedge HCLK);
    PENABLE = 1'b1;
    #1 data = to8 ? prdata8 : PRDATA;
    @(negedge HCLK);
    PSEL = 1'b0; psel8 = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_req(input int max, output bit found);
    found = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge HCLK);
      if (irq_req_o) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    HRESET = 1'b1;
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);
    vectors++;
    if (irq_req_o !== 1'b0 || irq_id_o !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: req=%b id=%0d, want req=0 id=0", irq_req_o, irq_id_o);
    end
    vectors++;
    if (PRDATA !== 32'h0 || PREADY !== 1'b1 || PSLVERR !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_apb: prdata=%h pready=%b pslverr=%b, want 0/1/0", PRDATA, PREADY, PSLVERR);
    end
    for (int a = 0; a < 6; a++) begin
      exp_q.push_back(32'h0);
      apb_read(1'b0, 12'(a * 4), rdata);
      exp = exp_q.pop_front();
      vectors++;
      if (rdata !== exp) begin
        miscompares++;
        $display("FAIL reset_reg[%0h]: got %h, want %h", a * 4, rdata, exp);
      end
    end
  endtask

  task automatic test_level;
    apb_write(1'b0, 12'h000, 32'h8);
    signal_i[3] = 1'b1;
    exp_q.push_back(32'd3);
    @(negedge HCLK);
    vectors++;
    if (irq_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL level_latency_early: req=%b, want 0", irq_req_o);
    end
    @(negedge HCLK);
    exp = exp_q.pop_front();
    vectors++;
    if (irq_req_o !== 1'b1 || 32'(irq_id_o) !== exp) begin
      miscompares++;
      $display("FAIL level_first_req: req=%b id=%0d, want req=1 id=%0d", irq_req_o, irq_id_o, exp);
    end
    irq_ack_i = 1'b1;
    exp_q.push_back(32'd3);
    @(negedge HCLK);
    irq_ack_i = 1'b0;
    vectors++;
    if (irq_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL level_idle_gap: req=%b, want 0", irq_req_o);
    end
    @(negedge HCLK);
    exp = exp_q.pop_front();
    vectors++;
    if (irq_req_o !== 1'b1 || 32'(irq_id_o) !== exp) begin
      miscompares++;
      $display("FAIL level_rereq: req=%b id=%0d, want req=1 id=%0d", irq_req_o, irq_id_o, exp);
    end
    signal_i[3] = 1'b0;
    irq_ack_i = 1'b1;
    @(negedge HCLK);
    irq_ack_i = 1'b0;
    exp_q.push_back(32'h0);
    apb_read(1'b0, 12'h004, rdata);
    exp = exp_q.pop_front();
    vectors++;
    if (rdata !== exp || irq_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL level_cleared: pending=%h req=%b, want %h req=0", rdata, irq_req_o, exp);
    end
    apb_write(1'b0, 12'h000, 32'h0);
  endtask

  task automatic test_edge;
    apb_write(1'b0, 12'h010, 32'h20);
    apb_write(1'b0, 12'h000, 32'h20);
    exp_q.push_back(32'd5);
    signal_i[5] = 1'b1;
    nreq = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge HCLK);
      irq_ack_i = 1'b0;
      if (i == 9) signal_i[5] = 1'b0;
      if (irq_req_o) begin
        nreq++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL edge_extra_req: got id=%0d, want no request", irq_id_o);
        end else begin
          exp = exp_q.pop_front();
          if (32'(irq_id_o) !== exp) begin
            miscompares++;
            $display("FAIL edge_id: got %0d, want %0d", irq_id_o, exp);
          end
        end
        irq_ack_i = 1'b1;
      end
    end
    irq_ack_i = 1'b0;
    vectors++;
    if (nreq != 1) begin
      miscompares++;
      $display("FAIL edge_count: got %0d requests, want 1", nreq);
    end
    exp_q.delete();
    exp_q.push_back(32'h0);
    apb_read(1'b0, 12'h004, rdata);
    exp = exp_q.pop_front();
    vectors++;
    if (rdata !== exp || irq_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL edge_after_ack: pending=%h req=%b, want %h req=0", rdata, irq_req_o, exp);
    end
  endtask

  task automatic test_priority;
    apb_write(1'b0, 12'h000, 32'h0);
    apb_write(1'b0, 12'h004, 32'h0000_0412);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd10);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      @(negedge HCLK);
      irq_ack_i = 1'b0;
      if (irq_req_o) begin
        exp = exp_q.pop_front();
        vectors++;
        if (32'(irq_id_o) !== exp) begin
          miscompares++;
          $display("FAIL prio_order: got id=%0d, want %0d", irq_id_o, exp);
        end
        irq_ack_i = 1'b1;
      end
    end
    @(negedge HCLK);
    irq_ack_i = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL prio_timeout: %0d requests outstanding, want 0", exp_q.size());
    end
    exp_q.delete();
    exp_q.push_back(32'h0);
    apb_read(1'b0, 12'h004, rdata);
    exp = exp_q.pop_front();
    vectors++;
    if (rdata !== exp) begin
      miscompares++;
      $display("FAIL prio_final_pending: got %h, want %h", rdata, exp);
    end
  endtask

  task automatic test_withdraw;
    apb_write(1'b0, 12'h004, 32'h4);
    exp_q.push_back(32'd2);
    wait_req(10, got);
    exp = exp_q.pop_front();
    vectors++;
    if (!got || 32'(irq_id_o) !== exp) begin
      miscompares++;
      $display("FAIL withdraw_req: req=%b id=%0d, want req=1 id=%0d", got, irq_id_o, exp);
    end
    exp_q.push_back(32'h8000_0002);
    apb_read(1'b0, 12'h014, rdata);
    exp = exp_q.pop_front();
    vectors++;
    if (rdata !== exp) begin
      miscompares++;
      $display("FAIL withdraw_status: got %h, want %h", rdata, exp);
    end
    apb_write(1'b0, 12'h00C, 32'h4);
    @(negedge HCLK);
    vectors++;
    if (irq_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL withdraw_drop: req=%b, want 0", irq_req_o);
    end
    repeat (3) @(negedge HCLK);
    vectors++;
    if (irq_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL withdraw_stays_low: req=%b, want 0", irq_req_o);
    end
  endtask

  task automatic test_set_clear;
    apb_write(1'b0, 12'h008, 32'h300);
    exp_q.push_back(32'h300);
    apb_read(1'b0, 12'h004, rdata);
    exp = exp_q.pop_front();
    vectors++;
    if (rdata !== exp) begin
      miscompares++;
      $display("FAIL set_pending: got %h, want %h", rdata, exp);
    end
    apb_write(1'b0, 12'h00C, 32'h100);
    exp_q.push_back(32'h200);
    apb_read(1'b0, 12'h004, rdata);
    exp = exp_q.pop_front();
    vectors++;
    if (rdata !== exp) begin
      miscompares++;
      $display("FAIL clear_pending: got %h, want %h", rdata, exp);
    end
    apb_write(1'b0, 12'h01C, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0);
    apb_read(1'b0, 12'h018, rdata);
    exp = exp_q.pop_front();
    vectors++;
    if (rdata !== exp) begin
      miscompares++;
      $display("FAIL unmapped_read: got %h, want %h", rdata, exp);
    end
    exp_q.push_back(32'h0);
    apb_read(1'b0, 12'h000, rdata);
    exp = exp_q.pop_front();
    vectors++;
    if (rdata !== exp) begin
      miscompares++;
      $display("FAIL unmapped_write_ignored: enable=%h, want %h", rdata, exp);
    end
    exp_q.push_back(32'd9);
    wait_req(10, got);
    exp = exp_q.pop_front();
    vectors++;
    if (!got || 32'(irq_id_o) !== exp) begin
      miscompares++;
      $display("FAIL set_next_id: req=%b id=%0d, want req=1 id=%0d", got, irq_id_o, exp);
    end
    apb_write(1'b0, 12'h00C, 32'h200);
    repeat (3) @(negedge HCLK);
    vectors++;
    if (irq_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL set_clear_idle: req=%b, want 0", irq_req_o);
    end
  endtask

  task automatic test_collision;
    apb_write(1'b0, 12'h010, 32'h40);
    apb_write(1'b0, 12'h000, 32'h40);
    exp_q.push_back(32'd6);
    signal_i[6] = 1'b1;
    repeat (2) @(negedge HCLK);
    exp = exp_q.pop_front();
    vectors++;
    if (irq_req_o !== 1'b1 || 32'(irq_id_o) !== exp) begin
      miscompares++;
      $display("FAIL coll_first_req: req=%b id=%0d, want req=1 id=%0d", irq_req_o, irq_id_o, exp);
    end
    signal_i[6] = 1'b0;
    @(negedge HCLK);
    signal_i[6] = 1'b1;
    irq_ack_i = 1'b1;
    exp_q.push_back(32'd6);
    @(negedge HCLK);
    irq_ack_i = 1'b0;
    vectors++;
    if (irq_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL coll_gap: req=%b, want 0", irq_req_o);
    end
    @(negedge HCLK);
    exp = exp_q.pop_front();
    vectors++;
    if (irq_req_o !== 1'b1 || 32'(irq_id_o) !== exp) begin
      miscompares++;
      $display("FAIL coll_rereq: req=%b id=%0d, want req=1 id=%0d", irq_req_o, irq_id_o, exp);
    end
    exp_q.push_back(32'h40);
    apb_read(1'b0, 12'h004, rdata);
    exp = exp_q.pop_front();
    vectors++;
    if (rdata !== exp) begin
      miscompares++;
      $display("FAIL coll_pending: got %h, want %h", rdata, exp);
    end
    irq_ack_i = 1'b1;
    @(negedge HCLK);
    irq_ack_i = 1'b0;
    repeat (2) @(negedge HCLK);
    signal_i[6] = 1'b0;
    vectors++;
    if (irq_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL coll_done: req=%b, want 0", irq_req_o);
    end
  endtask

  task automatic test_reset_mid_req;
    apb_write(1'b0, 12'h010, 32'h8);
    apb_write(1'b0, 12'h000, 32'h8);
    apb_write(1'b0, 12'h004, 32'h8);
    exp_q.push_back(32'd3);
    wait_req(10, got);
    exp = exp_q.pop_front();
    vectors++;
    if (!got || 32'(irq_id_o) !== exp) begin
      miscompares++;
      $display("FAIL rst_pre_req: req=%b id=%0d, want req=1 id=%0d", got, irq_id_o, exp);
    end
    HRESET = 1'b1;
    @(negedge HCLK);
    vectors++;
    if (irq_req_o !== 1'b0 || irq_id_o !== 5'd0) begin
      miscompares++;
      $display("FAIL rst_mid_req: req=%b id=%0d, want req=0 id=0", irq_req_o, irq_id_o);
    end
    HRESET = 1'b0;
    for (int a = 0; a < 6; a++) begin
      exp_q.push_back(32'h0);
      apb_read(1'b0, 12'(a * 4), rdata);
      exp = exp_q.pop_front();
      vectors++;
      if (rdata !== exp) begin
        miscompares++;
        $display("FAIL rst_reg[%0h]: got %h, want %h", a * 4, rdata, exp);
      end
    end
  endtask

  task automatic test_narrow;
    apb_write(1'b1, 12'h000, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_00FF);
    apb_read(1'b1, 12'h000, rdata);
    exp = exp_q.pop_front();
    vectors++;
    if (rdata !== exp) begin
      miscompares++;
      $display("FAIL narrow_enable: got %h, want %h", rdata, exp);
    end
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge();
    test_priority();
    test_withdraw();
    test_set_clear();
    test_collision();
    test_reset_mid_req();
    test_narrow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
